uart_cmd_rx: RTL and testbench
==============================

Name: uart_cmd_rx

Overview:
- UART receiver for the command path into the temperature-sensor macro.
- Deserialises the asynchronous serial line driven on the chip's rx input pin (ui_in[4]) into bytes for the command/threshold register logic.
- It is the receive counterpart of the macro's existing tx serialiser, which drives uo_out[0].
- Frame format: 8N1, LSB first, idle-high line, fixed baud from a clock-divider parameter.

Parameters:
- CLK_DIV, 87: clk cycles per bit (10 MHz / 115200). Legal range 4..4095. The counter is 12 bits wide.
- SYNC_STAGES, 2: number of metastability flops on rx. Legal range 2..3.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse when rx_data is updated
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values, applied asynchronously:
  - sync flops = 1
  - rx_data = 0x00; rx_valid, frame_err and busy = 0
  - state = IDLE; bit counter and baud counter = 0
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever delivered.
- Only the synchronised rx (rxs, the output of SYNC_STAGES flops) is used internally.
- State IDLE:
  - Baud counter held at 0.
  - rxs==0 moves to START and loads the counter.
- State START:
  - Count CLK_DIV/2 - 1 down to 0 (integer division). This reaches mid-start-bit.
  - At 0 with rxs==0: go to DATA, bit index = 0, load the counter with CLK_DIV-1.
  - At 0 with rxs==1: glitch. Return to IDLE; no output pulses.
- State DATA:
  - When the counter hits 0, shift rxs into shreg[bit index] (LSB first) and reload CLK_DIV-1.
  - After bit index 7 is sampled, go to STOP.
- State STOP (counter CLK_DIV-1 down to 0, then sample rxs):
  - rxs==1: on that edge rx_data <= shreg and rx_valid=1 for exactly one cycle. Go to IDLE.
  - rxs==0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- State BREAK:
  - Wait until rxs==1, then go to IDLE.
  - A held-low line (break) produces exactly one frame_err and no further activity.
- Latency:
  - rx_valid is registered high N clk edges after the first edge that sees rx low at the pin.
  - N = SYNC_STAGES + CLK_DIV/2 + 9*CLK_DIV.
  - This is exact for CLK_DIV even or odd, since CLK_DIV/2 truncates.
- Back-to-back frames:
  - A new start bit may begin on the cycle after the stop sample, because IDLE is entered that edge.
  - No idle gap is required. The next start is detected within 1 cycle.
- rx_valid and frame_err are never high in the same cycle.
- There is no ready/backpressure. The consumer must capture rx_data on rx_valid. rx_data stays stable until the next rx_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - An even-parity bit is expected between data bit 7 and the stop bit. A PARITY state is added, with a CLK_DIV-1 count and a sample at 0.
  - A port parity_err (output, 1, reset 0) is added.
  - On a good stop bit with a parity mismatch: parity_err pulses for one cycle, rx_valid stays 0, rx_data is unchanged.
  - Latency N grows by CLK_DIV.
  - Framing error takes precedence: with a bad stop bit, only frame_err pulses.
- When undefined: no parity state, no parity_err port; plain 8N1.

Test Plan (CLK_DIV=8, SYNC_STAGES=2 for speed):
- Send 0xA5 at 8 clk/bit -> rx_data=0xA5, rx_valid high exactly 1 cycle at edge 2+4+72=78 after start, frame_err=0, busy low afterwards.
- Send 0x00 then 0xFF with zero gap between the stop bit and the next start -> two rx_valid pulses, with rx_data 0x00 then 0xFF.
- Drive rx low for 2 clk, then high -> busy high briefly, returns to IDLE, no rx_valid, no frame_err. A following 0x3C is received correctly.
- Send 0x5A with stop bit low, held low 40 clk -> single frame_err pulse, rx_data keeps 0x3C, busy stays high until rx returns high.
- Assert reset during data bit 4 of 0x81, release, then send 0x42 -> all outputs 0 during reset, no pulse for the aborted frame, rx_data=0x42 with one rx_valid.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> rx_valid. Send 0x07 with parity 0 -> parity_err pulse, rx_data unchanged.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver for the temperature-sensor command path.
// Samples the synchronised rx line in the middle of each bit, LSB first, and
// pulses rx_valid for every well-formed byte or frame_err for a low stop bit.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit before the stop bit
// and a parity_err pulse output.
`timescale 1ns/1ps

module uart_cmd_rx #(
    parameter int CLK_DIV     = 87,   // clk cycles per bit, 4..4095
    parameter int SYNC_STAGES = 2     // metastability flops on rx, 2..3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // Counter reload values: full bit period, and half a bit to land mid-start-bit.
    localparam logic [11:0] C_FULL = 12'(CLK_DIV - 1);
    localparam logic [11:0] C_HALF = 12'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    state_t      r_state;
    logic [11:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shreg;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        w_good_byte;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bit;
    logic        r_parity_err;
`endif

    // Synchroniser chain; resets to the idle-high line level so no false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must contain an even number of ones.
    assign w_good_byte = ~(^{r_shreg, r_par_bit});
`else
    assign w_good_byte = 1'b1;
`endif

    // Receive FSM with registered data/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= C_HALF;
                    end
                end

                S_START: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else if (!w_rxs) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_cnt   <= C_FULL;
                    end else begin
                        // Start bit vanished by mid-bit: treat as a glitch.
                        r_state <= S_IDLE;
                    end
                end

                S_DATA: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else begin
                        r_shreg[r_bit] <= w_rxs;
                        r_cnt          <= C_FULL;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else begin
                        r_par_bit <= w_rxs;
                        r_cnt     <= C_FULL;
                        r_state   <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Good stop bit; a parity error (if enabled) suppresses delivery.
                            r_state <= S_IDLE;
                            if (w_good_byte) begin
                                r_rx_data  <= r_shreg;
                                r_rx_valid <= 1'b1;
                            end else begin
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= 1'b1;
`endif
                            end
                        end else begin
                            // Low stop bit wins over any parity result.
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx at 8 clk/bit, 2 sync stages.
`timescale 1ns/1ps

module tb_uart_cmd_rx;

    localparam int CLK_DIV     = 8;
    localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY = SYNC_STAGES + CLK_DIV / 2 + 10 * CLK_DIV;
`else
    localparam int LATENCY = SYNC_STAGES + CLK_DIV / 2 + 9 * CLK_DIV;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_cmd_rx #(
        .CLK_DIV    (CLK_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, sampled on the falling edge.
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_both = 0;
    int         last_valid_cyc = 0;
    int         start_edge = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            got_q.push_back(rx_data);
            $display("[TB] cycle %0d rx_valid data=0x%02h", cyc, rx_data);
        end
        if (frame_err) begin
            n_ferr <= n_ferr + 1;
            $display("[TB] cycle %0d frame_err", cyc);
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            n_perr <= n_perr + 1;
            $display("[TB] cycle %0d parity_err", cyc);
        end
`endif
        if (rx_valid && frame_err) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity bit, stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_edge = cyc + 1;
        hold(1'b0, CLK_DIV);
        for (int i = 0; i < 8; i++) hold(d[i], CLK_DIV);
`ifdef UART_RX_PARITY_EN
        hold(par, CLK_DIV);
`else
        if (par === 1'bx) $display("[TB] parity arg unused");
`endif
        hold(stop, CLK_DIV);
    endtask

    initial begin
        bit seen_busy;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        hold(1'b1, 5);

        // 1: single byte and exact latency.
        send_frame(8'hA5, ^8'hA5, 1'b1);
        hold(1'b1, 3);
        check("t1_valid_count", n_valid, 1);
        check("t1_data", {24'd0, got_q[0]}, 32'hA5);
        check("t1_latency_edge", last_valid_cyc, start_edge + LATENCY);
        check("t1_frame_err", n_ferr, 0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // 2: back-to-back frames with no idle gap.
        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        hold(1'b1, 3);
        check("t2_valid_count", n_valid, 3);
        check("t2_data0", {24'd0, got_q[1]}, 32'h00);
        check("t2_data1", {24'd0, got_q[2]}, 32'hFF);

        // 3: 2-cycle glitch, then a real byte.
        seen_busy = 1'b0;
        hold(1'b0, 2);
        rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("t3_busy_seen", {31'd0, seen_busy}, 32'd1);
        check("t3_busy_idle", {31'd0, busy}, 32'd0);
        check("t3_no_valid", n_valid, 3);
        check("t3_no_ferr", n_ferr, 0);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        hold(1'b1, 3);
        check("t3_valid_count", n_valid, 4);
        check("t3_data", {24'd0, got_q[3]}, 32'h3C);

        // 4: low stop bit held as a break.
        start_edge = cyc + 1;
        hold(1'b0, CLK_DIV);
        for (int i = 0; i < 8; i++) hold(((8'h5A >> i) & 8'h01) != 8'h00, CLK_DIV);
`ifdef UART_RX_PARITY_EN
        hold(^8'h5A, CLK_DIV);
`endif
        hold(1'b0, 40);
        check("t4_ferr_count", n_ferr, 1);
        check("t4_valid_count", n_valid, 4);
        check("t4_rx_data_kept", {24'd0, rx_data}, 32'h3C);
        check("t4_busy_in_break", {31'd0, busy}, 32'd1);
        hold(1'b1, 6);
        check("t4_busy_released", {31'd0, busy}, 32'd0);
        check("t4_ferr_still_one", n_ferr, 1);

        // 5: reset during data bit 4 of 0x81.
        hold(1'b0, CLK_DIV);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 8'h00, CLK_DIV);
        hold(1'b0, CLK_DIV / 2);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_rx_data", {24'd0, rx_data}, 32'h00);
        @(negedge clk);
        check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
        hold(1'b1, 3);
        reset = 1'b0;
        hold(1'b1, 20);
        check("t5_no_pulse_valid", n_valid, 4);
        check("t5_no_pulse_ferr", n_ferr, 1);
        send_frame(8'h42, ^8'h42, 1'b1);
        hold(1'b1, 3);
        check("t5_valid_count", n_valid, 5);
        check("t5_data", {24'd0, got_q[4]}, 32'h42);

`ifdef UART_RX_PARITY_EN
        // 6: even parity good and bad.
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 3);
        check("t6_valid_count", n_valid, 6);
        check("t6_data", {24'd0, got_q[5]}, 32'h07);
        check("t6_perr_none", n_perr, 0);
        send_frame(8'h07, 1'b0, 1'b1);
        hold(1'b1, 3);
        check("t6_perr_count", n_perr, 1);
        check("t6_valid_unchanged", n_valid, 6);
        check("t6_rx_data_kept", {24'd0, rx_data}, 32'h07);
`endif

        check("never_valid_and_ferr", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
